mul32_seq: RTL and testbench
============================

Name: mul32_seq

Overview:
- Sequential unsigned 32x32 -> 64-bit multiplier, shift-add, one multiplier bit per clock.
- Used as a shared arithmetic resource by a controller that drives a four-phase en/ready handshake.
- Trades area for latency: one adder of width WIDTH+1, one counter, a small FSM.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Verification targets WIDTH=32 only.

Ports:
- clk    input   1        system clock, all logic on rising edge
- nrst   input   1        synchronous reset, active-high (asserted = 1, sampled on rising clk edge only; name kept per codebase convention)
- en     input   1        request; level-sensitive, four-phase handshake
- a      input   WIDTH    multiplicand, unsigned
- b      input   WIDTH    multiplier, unsigned
- ready  output  1        result valid / request acknowledged
- result output  2*WIDTH  product a*b, unsigned

Behaviour:
- Reset (nrst=1 at rising edge): state=IDLE, ready=0, result=0, counter=0, internal operand/accumulator regs=0. Reset has priority over all other inputs, including mid-operation; an aborted operation leaves no trace.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready=0.
  - en=1 at edge k: latch a and b into internal regs, clear accumulator and counter, go to BUSY.
  - en=0: stay in IDLE.
- BUSY:
  - Each edge processes multiplier bit i (LSB first): if bit set, add multiplicand into the upper half of the accumulator (carry kept); then shift the accumulator right by 1.
  - After WIDTH bits (edge k+32 for WIDTH=32): write the accumulator to result, set ready=1, go to DONE.
  - Latency is 32 clock edges from the start edge to ready high.
  - a, b and en are ignored while in BUSY; operands come only from the latched copies.
- DONE:
  - ready=1.
  - Stay in DONE while en=1.
  - On an edge with en=0: ready=0, go to IDLE.
  - If en was already low on reaching DONE, ready is high for exactly one cycle.
- result:
  - Changes only at the BUSY->DONE edge, or on reset.
  - Holds its value through DONE, after ready falls, and through IDLE and the next BUSY, until the next completion.
  - Consumers read it after ready rises, or at any time after ready falls and before the next completion.
- No re-trigger: a new operation starts only from IDLE with en=1. DONE is left only after en falls, so a held-high en never causes back-to-back starts.
- Arithmetic: exact unsigned product, no overflow possible.
  - Boundary: 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001.
  - Zero operands produce 0 with the same latency; there is no early termination.
- Simultaneous events:
  - nrst=1 together with en=1 -> reset wins; the operation is not started.
  - en dropped during BUSY -> the operation completes and ready pulses one cycle.

Optional Feature:
- Macro MUL32_RADIX4_EN.
- Defined: two multiplier bits per cycle, using the partial-product set {0, a, 2a, 3a}, with 3a precomputed once at the start edge. BUSY lasts WIDTH/2 = 16 cycles. All handshake, reset and result-hold rules are unchanged.
- Undefined: radix-2, 32-cycle latency as above.

Test Plan:
- Reset: hold nrst=1 for 10 cycles with en=1, a=b=0xFFFFFFFF -> ready=0 and result=0 throughout; no operation starts after release while en is toggled low first.
- Basic: a=3, b=5, en=1 -> ready rises exactly 32 edges after the start (16 with MUL32_RADIX4_EN), result=15; drop en -> ready=0 one edge later and result stays 15.
- Extremes: 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001; 0x80000000*2 -> 0x0000000100000000; 0*0x12345678 -> 0.
- Operand change: change a and b on every cycle during BUSY -> result equals the product of the values latched at the start edge.
- Handshake: hold en=1 for 100 cycles after ready -> ready stays 1, no restart, result stable. Separately, drop en at cycle 5 of BUSY -> ready is a single-cycle pulse with the correct result.
- Mid-op reset and random: assert nrst at BUSY cycle 10 -> IDLE, result=0. Then 20 random $urandom pairs through the full handshake -> every result equals the 64-bit golden product, 0 errors.

Source files
------------

// File: rtl/mul32_seq.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier behind a four-phase en/ready handshake.
// Define MUL32_RADIX4_EN to retire two multiplier bits per cycle using the partial products {0, a, 2a, 3a}.
module mul32_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           o_dbg_state
);

`ifdef MUL32_RADIX4_EN
  localparam int SH = 2;
`else
  localparam int SH = 1;
`endif
  localparam int STEPS = WIDTH / SH;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH+SH-1:0]  w_pp;
  logic [WIDTH+SH-1:0]  w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_last;

  // Handshake: a request is en held high in IDLE; ready is high exactly while in DONE,
  // and DONE is left only once en has been observed low, so held-high en never restarts.

`ifdef MUL32_RADIX4_EN
  logic [WIDTH+1:0] r_mcand3;

  always_comb begin
    w_pp = '0;
    case (r_acc[1:0])
      2'd0:    w_pp = '0;
      2'd1:    w_pp = {2'b00, r_mcand};
      2'd2:    w_pp = {1'b0, r_mcand, 1'b0};
      default: w_pp = r_mcand3;
    endcase
  end
`else
  always_comb begin
    w_pp = r_acc[0] ? {1'b0, r_mcand} : '0;
  end
`endif

  // The low half of the accumulator starts as the multiplier and is consumed from the LSB
  // as the partial sum shifts in from the top.
  always_comb begin
    w_sum      = {{SH{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;
    w_acc_next = {w_sum, r_acc[WIDTH-1:SH]};
    w_last     = (r_cnt == CW'(STEPS - 1));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (en)     w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  if (!en)    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
`ifdef MUL32_RADIX4_EN
      r_mcand3 <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_mcand  <= a;
            r_acc    <= {{WIDTH{1'b0}}, b};
            r_cnt    <= '0;
`ifdef MUL32_RADIX4_EN
            r_mcand3 <= {2'b00, a} + {1'b0, a, 1'b0};
`endif
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_result <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

  assign ready       = (r_state == S_DONE);
  assign result      = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul32_seq.sv
// Testbench for mul32_seq: driver tasks issue handshaked operations and push the golden product;
// a monitor pops and compares on every rising ready.
module tb_mul32_seq;

`ifdef MUL32_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk;
  logic        nrst;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic [63:0] result;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_ready = 1'b0;

  mul32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .result      (result),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(ready), 64'(0));
      end else begin
        check("product", result, exp_q.pop_front());
      end
    end
    prev_ready = ready;
  end

  // driver: one full handshake; drop_at>0 lowers en at that BUSY cycle, scramble churns a/b during BUSY
  task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                       input int drop_at, input int hold_after, input bit scramble);
    logic [63:0] exp;
    int          n;
    bit          dropped;
    exp = {32'b0, op_a} * {32'b0, op_b};
    @(negedge clk);
    a = op_a;
    b = op_b;
    en = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    n = 0;
    dropped = 1'b0;
    forever begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n > 4 * LAT) break;
      if (scramble) begin
        a = $urandom;
        b = $urandom;
      end
      if (n == drop_at) begin
        en = 1'b0;
        dropped = 1'b1;
      end
    end
    check("latency", 64'(n), 64'(LAT));
    for (int i = 0; i < hold_after; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(ready), 64'(1));
      check("hold_result", result, exp);
    end
    en = 1'b0;
    @(negedge clk);
    check("ready_fall", 64'(ready), 64'(0));
    check("result_after_fall", result, exp);
    repeat (3) @(negedge clk);
    check("idle_ready", 64'(ready), 64'(0));
    check("idle_result_hold", result, exp);
  endtask

  initial begin
    int ready_hits;
    int drop;
    nrst = 1'b1;
    en   = 1'b1;
    a    = 32'hFFFF_FFFF;
    b    = 32'hFFFF_FFFF;

    // reset held with a pending request
    repeat (10) begin
      @(negedge clk);
      check("reset_ready", 64'(ready), 64'(0));
      check("reset_result", result, 64'(0));
    end
    en = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    ready_hits = 0;
    repeat (LAT + 8) begin
      @(negedge clk);
      if (ready) ready_hits++;
    end
    check("no_start_after_reset", 64'(ready_hits), 64'(0));
    check("result_zero_after_reset", result, 64'(0));

    // basic and extremes
    do_op(32'd3, 32'd5, 0, 0, 1'b0);
    check("basic_value", result, 64'd15);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("max_value", result, 64'hFFFF_FFFE_0000_0001);
    do_op(32'h8000_0000, 32'd2, 0, 0, 1'b0);
    check("msb_value", result, 64'h0000_0001_0000_0000);
    do_op(32'd0, 32'h1234_5678, 0, 0, 1'b0);
    check("zero_value", result, 64'd0);

    // operands churned during BUSY
    do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 1'b1);

    // en held long after ready, then en dropped early in BUSY
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 0, 100, 1'b0);
    do_op(32'h0000_FFFF, 32'hFFFF_0000, 5, 0, 1'b0);

    // reset in the middle of an operation
    @(negedge clk);
    a  = 32'h7777_7777;
    b  = 32'h3333_3333;
    en = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    nrst = 1'b1;
    en   = 1'b0;
    @(negedge clk);
    check("midop_reset_ready", 64'(ready), 64'(0));
    check("midop_reset_result", result, 64'(0));
    nrst = 1'b0;
    ready_hits = 0;
    repeat (LAT + 8) begin
      @(negedge clk);
      if (ready) ready_hits++;
    end
    check("midop_no_trace", 64'(ready_hits), 64'(0));

    // random operations
    for (int i = 0; i < 20; i++) begin
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT - 1) : 0;
      do_op($urandom, $urandom, drop, (drop != 0) ? 0 : $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
